// File: rtl/imuldiv_int_mul_div_dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imuldiv_int_mul_div_dispatch_pkg
//  Description : Shared definitions for the mul/div dispatch front-end:
//                operation codes, response-source tag encoding and a helper
//                that maps an operation code onto its tag.
//  Revision    : 1.0 - initial release
// ============================================================================
package imuldiv_int_mul_div_dispatch_pkg;

    // Operation codes carried on muldivreq_msg_fn; 5..7 are reserved (NONE)
    localparam logic [2:0] c_FN_MUL  = 3'd0;
    localparam logic [2:0] c_FN_DIV  = 3'd1;
    localparam logic [2:0] c_FN_DIVU = 3'd2;
    localparam logic [2:0] c_FN_REM  = 3'd3;
    localparam logic [2:0] c_FN_REMU = 3'd4;

    // Which unit owes the response for an outstanding operation
    typedef enum logic [1:0] {
        SRC_MUL  = 2'd0,
        SRC_DIV  = 2'd1,
        SRC_NONE = 2'd2
    } src_e;

    // One tag per outstanding operation; hi selects the remainder half
    typedef struct packed {
        src_e src;
        logic hi;
    } tag_t;

    localparam int c_TAG_W = $bits(tag_t);

    // Classify an incoming operation code into the tag that is queued for it
    function automatic tag_t fn_to_tag(input logic [2:0] fn);
        tag_t t;
        t.src = SRC_NONE;
        t.hi  = 1'b0;
        case (fn)
            c_FN_MUL:             t.src = SRC_MUL;
            c_FN_DIV, c_FN_DIVU:  t.src = SRC_DIV;
            c_FN_REM, c_FN_REMU: begin
                t.src = SRC_DIV;
                t.hi  = 1'b1;
            end
            default:              t.src = SRC_NONE;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imuldiv_MulDivTagQueue.sv
`default_nettype none
// ============================================================================
//  Module      : imuldiv_MulDivTagQueue
//  Description : Circular FIFO of response tags. Head entry is presented
//                combinationally; full/empty come from the registered count.
//                Enqueue while full and dequeue while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module imuldiv_MulDivTagQueue
    import imuldiv_int_mul_div_dispatch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq_val,
    input  tag_t             enq_tag,
    input  logic             deq_val,
    output tag_t             deq_tag,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    tag_t             entries_q [DEPTH];
    tag_t             entries_d [DEPTH];

    logic             w_do_enq;
    logic             w_do_deq;

    // Pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_q == c_CNT_FULL);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign deq_tag  = entries_q[head_q];
    assign w_do_enq = enq_val & ~full;
    assign w_do_deq = deq_val & ~empty;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (w_do_enq) begin
            entries_d[tail_q] = enq_tag;
            tail_d            = ptr_inc(tail_q);
        end
        if (w_do_deq) begin
            head_d = ptr_inc(head_q);
        end
        case ({w_do_enq, w_do_deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state clears on reset; payload storage needs no reset
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Tag storage update
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

endmodule
`default_nettype wire

// File: rtl/imuldiv_int_mul_div_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : imuldiv_int_mul_div_dispatch
//  Description : Steers muldiv requests to the iterative multiplier or
//                divider, remembers issue order in a tag queue and merges the
//                unit responses into one in-order 32-bit response stream.
//                Optional macro IMULDIV_DISPATCH_PIPE_EN adds a one-entry
//                output register on the response (+1 cycle, full rate).
//  Revision    : 1.0 - initial release
// ============================================================================
module imuldiv_int_mul_div_dispatch
    import imuldiv_int_mul_div_dispatch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [2:0]  muldivreq_msg_fn,
    input  logic [31:0] muldivreq_msg_a,
    input  logic [31:0] muldivreq_msg_b,
    input  logic        muldivreq_val,
    output logic        muldivreq_rdy,

    output logic [31:0] mulreq_msg_a,
    output logic [31:0] mulreq_msg_b,
    output logic        mulreq_val,
    input  logic        mulreq_rdy,

    input  logic [63:0] mulresp_msg_result,
    input  logic        mulresp_val,
    output logic        mulresp_rdy,

    output logic [2:0]  divreq_msg_fn,
    output logic [31:0] divreq_msg_a,
    output logic [31:0] divreq_msg_b,
    output logic        divreq_val,
    input  logic        divreq_rdy,

    input  logic [63:0] divresp_msg_result,
    input  logic        divresp_val,
    output logic        divresp_rdy,

    output logic [31:0] muldivresp_msg_result,
    output logic        muldivresp_val,
    input  logic        muldivresp_rdy
);

    localparam int CNT_W = $clog2(QDEPTH + 1);

    tag_t             w_req_tag;
    tag_t             w_head_tag;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_enq;
    logic             w_deq;
    logic             w_req_rdy;

    logic             w_head_val;
    logic [31:0]      w_head_result;
    logic             w_sel_mul;
    logic             w_sel_div;
    logic             w_unused;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign w_req_tag     = fn_to_tag(muldivreq_msg_fn);

    assign mulreq_msg_a  = muldivreq_msg_a;
    assign mulreq_msg_b  = muldivreq_msg_b;
    assign divreq_msg_fn = muldivreq_msg_fn;
    assign divreq_msg_a  = muldivreq_msg_a;
    assign divreq_msg_b  = muldivreq_msg_b;

    // Only the selected unit sees val; full looks at the registered count
    // alone so a same-cycle response never opens a path to request ready
    always_comb begin
        mulreq_val = 1'b0;
        divreq_val = 1'b0;
        w_req_rdy  = 1'b0;
        case (w_req_tag.src)
            SRC_MUL: begin
                mulreq_val = muldivreq_val & ~w_full;
                w_req_rdy  = mulreq_rdy & ~w_full;
            end
            SRC_DIV: begin
                divreq_val = muldivreq_val & ~w_full;
                w_req_rdy  = divreq_rdy & ~w_full;
            end
            default: begin
                w_req_rdy  = ~w_full;
            end
        endcase
    end

    assign muldivreq_rdy = w_req_rdy;
    assign w_enq         = muldivreq_val & w_req_rdy;

    imuldiv_MulDivTagQueue #(
        .DEPTH   (QDEPTH)
    ) u_tag_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (w_enq),
        .enq_tag (w_req_tag),
        .deq_val (w_deq),
        .deq_tag (w_head_tag),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------
    // Only the unit owed the oldest response is looked at; the other one is
    // left holding its response until its tag reaches the head
    always_comb begin
        w_head_val    = 1'b0;
        w_head_result = '0;
        w_sel_mul     = 1'b0;
        w_sel_div     = 1'b0;
        if (!w_empty) begin
            case (w_head_tag.src)
                SRC_MUL: begin
                    w_sel_mul     = 1'b1;
                    w_head_val    = mulresp_val;
                    w_head_result = mulresp_msg_result[31:0];
                end
                SRC_DIV: begin
                    w_sel_div     = 1'b1;
                    w_head_val    = divresp_val;
                    w_head_result = w_head_tag.hi ? divresp_msg_result[63:32]
                                                  : divresp_msg_result[31:0];
                end
                default: begin
                    w_head_val    = 1'b1;
                    w_head_result = '0;
                end
            endcase
        end
    end

`ifdef IMULDIV_DISPATCH_PIPE_EN
    logic        out_val_q, out_val_d;
    logic [31:0] out_result_q, out_result_d;
    logic        w_load_en;
    logic        w_load;

    // The register may refill in the same cycle it drains, keeping full rate
    assign w_load_en   = ~out_val_q | muldivresp_rdy;
    assign w_load      = w_head_val & w_load_en;
    assign w_deq       = w_load;
    assign mulresp_rdy = w_sel_mul & w_load_en;
    assign divresp_rdy = w_sel_div & w_load_en;

    // Output register next-state: load wins over drain
    always_comb begin
        out_val_d    = out_val_q;
        out_result_d = out_result_q;
        if (w_load) begin
            out_val_d    = 1'b1;
            out_result_d = w_head_result;
        end else if (muldivresp_rdy) begin
            out_val_d    = 1'b0;
        end
    end

    // Output register state
    always_ff @(posedge clk) begin
        if (reset) begin
            out_val_q    <= 1'b0;
            out_result_q <= '0;
        end else begin
            out_val_q    <= out_val_d;
            out_result_q <= out_result_d;
        end
    end

    assign muldivresp_val        = out_val_q;
    assign muldivresp_msg_result = out_result_q;
`else
    assign mulresp_rdy           = w_sel_mul & muldivresp_rdy;
    assign divresp_rdy           = w_sel_div & muldivresp_rdy;
    assign muldivresp_val        = w_head_val;
    assign muldivresp_msg_result = w_head_result;
    assign w_deq                 = w_head_val & muldivresp_rdy;
`endif

    // The multiplier's upper half and the occupancy count are not consumed
    assign w_unused = ^{w_count, mulresp_msg_result[63:32]};

endmodule
`default_nettype wire
